// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 width codes, FSM states and byte-lane helpers shared by the LSU
package load_store_unit_pkg;
  localparam int LSU_XLEN = 32;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
    return (we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
               : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU))
           && !(f3[1:0] == 2'b01 && off[0]) && !(f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    return sz == 2'b10 ? 4'b1111 : sz == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b0001 << off;
  endfunction
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    return sz == 2'b00 ? {4{wd[7:0]}} : sz == 2'b01 ? {2{wd[15:0]}} : wd;
  endfunction
endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: picks the addressed lane of a read word and sign/zero-extends it (funct3, off, word -> data)
module load_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);
  logic [XLEN-1:0] w;
  always_comb begin
    w = word >> {off, 3'b000};
    data = funct3 == F3_B  ? {{(XLEN-8){w[7]}}, w[7:0]} :
           funct3 == F3_H  ? {{(XLEN-16){w[15]}}, w[15:0]} :
           funct3 == F3_BU ? {{(XLEN-8){1'b0}}, w[7:0]} :
           funct3 == F3_HU ? {{(XLEN-16){1'b0}}, w[15:0]} : word;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store FSM; req_* from execute, resp_* completion, mem_* word-wide memory port
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] rdata,
  output logic            err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid
);
  lsu_state_e state_q, state_d;
  logic we_q, we_d, err_q, err_d;
  logic [2:0] f3_q, f3_d;
  logic [3:0] be_q, be_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, load_data;
  load_align #(.XLEN(XLEN)) u_align (.funct3(f3_q), .off(addr_q[1:0]), .word(mem_rdata), .data(load_data));
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    f3_d = f3_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d = req_we;
        f3_d = funct3;
        addr_d = addr;
        be_d = lane_be(funct3[1:0], addr[1:0]);
        wdata_d = lane_wdata(funct3[1:0], wdata);
        if (access_ok(req_we, funct3, addr[1:0])) state_d = REQ;
        else begin
          state_d = DONE;
          err_d = 1'b1;
          rdata_d = '0;
        end
      end
      REQ: if (mem_ready) begin
        state_d = we_q ? DONE : WAIT;
        if (we_q) begin
          rdata_d = '0;
          err_d = 1'b0;
        end
      end
      WAIT: if (mem_rvalid) begin
        state_d = DONE;
        rdata_d = load_data;
        err_d = 1'b0;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == DONE;
  assign mem_valid = state_q == REQ;
  assign mem_we = mem_valid & we_q;
  assign mem_addr = {addr_q[XLEN-1:2], 2'b00};
  assign mem_be = be_q;
  assign mem_wdata = wdata_q;
  assign rdata = rdata_q;
  assign err = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench driving loads/stores/errors/reset-abort through load_store_unit
module tb_load_store_unit;
  logic clk = 1'b0, rst, req_valid, req_we, mem_ready, mem_rvalid;
  logic req_ready, resp_valid, err, mem_valid, mem_we;
  logic [2:0] funct3;
  logic [3:0] mem_be;
  logic [31:0] addr, wdata, mem_rdata, rdata, mem_addr, mem_wdata;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [31:0] rd; logic er; int lat;} exp_t;
  exp_t exp_q[$];

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata),
    .err(err), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] mw, input int dly,
                     input logic [31:0] erd, input logic eer, input logic [31:0] emaddr,
                     input logic [3:0] ebe, input logic [31:0] ewd);
    exp_t e;
    int n, rc;
    logic seen, granted;
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{ebe[i]}};
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    e.rd = erd; e.er = eer; e.lat = eer ? 2 : (we ? 3 : 4) + dly;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 2; rc = 0; seen = 1'b0; granted = 1'b0;
    while (!resp_valid && n < 40) begin
      mem_rvalid = granted && !we;
      mem_rdata = mw;
      granted = 1'b0;
      if (mem_valid) begin
        if (!seen) begin
          chk({tag, "_maddr"}, mem_addr, emaddr);
          chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, ebe});
          chk({tag, "_mwe"}, {31'd0, mem_we}, {31'd0, we});
          if (we) chk({tag, "_mwdata"}, mem_wdata & m, ewd & m);
        end
        seen = 1'b1;
        mem_ready = rc == dly;
        granted = mem_ready;
        rc++;
      end else mem_ready = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    mem_rvalid = 1'b0;
    mem_ready = 1'b0;
    if (!resp_valid) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_rdata"}, rdata, e.rd);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e.er});
    chk({tag, "_memseen"}, {31'd0, seen}, {31'd0, !e.er});
    chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_hold"}, rdata, e.rd);
    chk({tag, "_errhold"}, {31'd0, err}, {31'd0, e.er});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_memv", {31'd0, mem_valid}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    @(negedge clk); rst = 1'b0;
    //      tag    we    f3      addr          wdata         mem word      dly rdata         err   maddr         be       wdata
    txn("lw",   1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b0, 32'h100, 4'b1111, 32'h0);
    txn("lb",   1'b0, 3'b000, 32'h103, 32'h0,        32'h80123456, 0, 32'hFFFFFF80, 1'b0, 32'h100, 4'b1000, 32'h0);
    txn("lbu",  1'b0, 3'b100, 32'h103, 32'h0,        32'h80123456, 0, 32'h00000080, 1'b0, 32'h100, 4'b1000, 32'h0);
    txn("lhu",  1'b0, 3'b101, 32'h102, 32'h0,        32'h80123456, 1, 32'h00008012, 1'b0, 32'h100, 4'b1100, 32'h0);
    txn("lh",   1'b0, 3'b001, 32'h100, 32'h0,        32'h12348765, 0, 32'hFFFF8765, 1'b0, 32'h100, 4'b0011, 32'h0);
    txn("sh",   1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        0, 32'h0,        1'b0, 32'h200, 4'b1100, 32'hABCD0000);
    txn("sw",   1'b1, 3'b010, 32'h204, 32'h11223344, 32'h0,        1, 32'h0,        1'b0, 32'h204, 4'b1111, 32'h11223344);
    txn("lwmis",1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 32'h0,        1'b1, 32'h0,   4'b0,    32'h0);
    txn("lh_ok",1'b0, 3'b101, 32'h10E, 32'h0,        32'hCAFE0000, 0, 32'h0000CAFE, 1'b0, 32'h10C, 4'b1100, 32'h0);
    txn("f011", 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 32'h0,        1'b1, 32'h0,   4'b0,    32'h0);
    txn("shmis",1'b1, 3'b001, 32'h203, 32'h1,        32'h0,        0, 32'h0,        1'b1, 32'h0,   4'b0,    32'h0);
    txn("slbu", 1'b1, 3'b100, 32'h200, 32'h1,        32'h0,        0, 32'h0,        1'b1, 32'h0,   4'b0,    32'h0);
    txn("sb",   1'b1, 3'b000, 32'h300, 32'h0000007F, 32'h0,        0, 32'h0,        1'b0, 32'h300, 4'b0001, 32'h0000007F);
    txn("lbu2", 1'b0, 3'b100, 32'h300, 32'h0,        32'h0000007F, 0, 32'h0000007F, 1'b0, 32'h300, 4'b0001, 32'h0);
    txn("sb1",  1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        0, 32'h0,        1'b0, 32'h300, 4'b0010, 32'h0000A500);
    txn("lw2",  1'b0, 3'b010, 32'h404, 32'h0,        32'h55AA00FF, 0, 32'h55AA00FF, 1'b0, 32'h404, 4'b1111, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("abort_inwait", {31'd0, mem_valid | req_ready | resp_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_async", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_noresp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    chk("abort_memv", {30'd0, mem_valid, mem_we}, 32'd0);
    chk("abort_maddr", mem_addr, 32'd0);
    chk("abort_be", {28'd0, mem_be}, 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: XLEN, 32 (from riscv.h), data/address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  access request from execute stage.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I width/sign code.
REQ-008 addr  input  XLEN  byte address (ALU out).
REQ-009 wdata  input  XLEN  store data (rs2).
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 rdata  output  XLEN  aligned, extended load result.
REQ-012 err  output  1  misaligned/illegal access, valid with resp_valid.
REQ-013 mem_valid  output  1  memory request.
REQ-014 mem_ready  input  1  memory accepts request.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  XLEN  word address, bits [1:0] = 0.
REQ-017 mem_be  output  4  byte enables.
REQ-018 mem_wdata  output  XLEN  lane-shifted store data.
REQ-019 mem_rdata  input  XLEN  read word.
REQ-020 mem_rvalid  input  1  mem_rdata valid.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE; req_ready = 1 only in IDLE.
REQ-022 IDLE: req_valid & req_ready latches req_we, funct3, addr, wdata; legal -> REQ, illegal -> DONE with err=1.
REQ-023 Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101; legal stores: SB 000, SH 001, SW 010; all other codes illegal.
REQ-024 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; treated as illegal, no memory access issued.
REQ-025 REQ: mem_valid=1, fields held stable until mem_ready; store -> DONE, load -> WAIT on the mem_ready cycle.
REQ-026 WAIT: on mem_rvalid, capture aligned/extended mem_rdata into rdata register, -> DONE.
REQ-027 mem_rvalid outside WAIT is ignored.
REQ-028 DONE: resp_valid=1 for exactly one cycle, -> IDLE; no request accepted in DONE.
REQ-029 Byte lanes: SB be=0001<<addr[1:0], SH be=0011<<{addr[1],0}, SW be=1111; wdata replicated into lanes.
REQ-030 Loads select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
REQ-031 rdata = 0 for stores and errored accesses; rdata/err hold last value until next DONE.
REQ-032 Minimum latency: store 3 cycles, load 4 cycles from accept to resp_valid (zero-wait memory); error 2 cycles.

Reset
REQ-033 rst asserted at any time forces IDLE immediately, aborting any in-flight access.
REQ-034 Reset values: req_ready=1 after release, resp_valid=0, rdata=0, err=0, mem_valid=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
REQ-035 A mem_rvalid arriving after reset for an aborted load is ignored.

Structure
REQ-036 funct3 load/store codes and state encoding in shared header lsu_codes.h; XLEN from riscv.h.
REQ-037 Combinational lane select and extension in sub-module load_align; FSM and registers in load_store_unit.

Verification
REQ-038 LW addr=0x100, mem_rdata=0xDEADBEEF, 2-cycle mem_ready delay -> mem_addr=0x100, be=1111, rdata=0xDEADBEEF, err=0, resp_valid 6 cycles after accept.
REQ-039 LB addr=0x103, mem_rdata=0x80123456 -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x00008012.
REQ-040 SH addr=0x202, wdata=0x0000ABCD -> mem_we=1, mem_addr=0x200, be=1100, mem_wdata[31:16]=0xABCD, resp_valid, rdata=0.
REQ-041 LW addr=0x101 and funct3=011 -> no mem_valid, resp_valid with err=1 two cycles after accept.
REQ-042 rst pulsed in WAIT, then stray mem_rvalid -> outputs at reset values, no resp_valid, req_ready=1.
REQ-043 Back-to-back SB then LBU same address (0x300, 0x7F) -> second request accepted only after DONE, rdata=0x0000007F.
